// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: fetch state encoding,
// bubble encoding and the field widths used by fetch, decode and the hazard unit.
package cpu_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;
  localparam int OPCODE_W    = 4;
  localparam int REG_ADDR_W  = 4;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Ready-handshaked instruction memory port between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_ifid_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry holding register for a word that returned from memory while
// the IF/ID register could not accept it.
module fetch_skid_buf #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drop,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc_plus1,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus1
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc_plus1 <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= load_instr;
      pc_plus1 <= load_pc_plus1;
    end else if (drop) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage with IF/ID pipeline register, PC ownership and
// branch/stall handling.
//
//   state | meaning
//   FETCH | request at pc outstanding; completions go straight to IF/ID
//   FULL  | word parked in skid buffer while decode is stalled; no request
//   DRAIN | wrong-path request still outstanding after a redirect; data dropped
module fetch_ifid_stage
  import cpu_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(cpu_pkg::NOP_INSTR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_stall,
  input  logic                ifid_stall,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_target,
  fetch_ifid_stage_if.master  imem,
  output logic [INSTR_W-1:0]  d_instr,
  output logic [PC_W-1:0]     d_pc_plus1,
  output logic                d_valid
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_t       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    req_addr;
  logic               done;
  logic               stall_any;
  logic               skid_load;
  logic               skid_drop;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc_plus1;

  assign imem.imem_req  = !rst && (state != FULL);
  assign imem.imem_addr = req_addr;
  assign done           = imem.imem_req && imem.imem_ready;
  assign stall_any      = pc_stall || ifid_stall;

  assign skid_load = !rst && (state == FETCH) && done && !br_taken && stall_any;
  assign skid_drop = !rst && (state == FULL) && (br_taken || !stall_any);

  fetch_skid_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk           (clk),
    .rst           (rst),
    .load          (skid_load),
    .drop          (skid_drop),
    .load_instr    (imem.imem_rdata),
    .load_pc_plus1 (req_addr + PC_ONE),
    .valid         (skid_valid),
    .instr         (skid_instr),
    .pc_plus1      (skid_pc_plus1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      d_instr    <= NOP_INSTR;
      d_pc_plus1 <= '0;
      d_valid    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (br_taken) begin
            pc      <= br_target;
            d_instr <= NOP_INSTR;
            d_valid <= 1'b0;
            // A completing wrong-path word is simply dropped; otherwise wait it out.
            if (done) req_addr <= br_target;
            else      state    <= DRAIN;
          end else if (done) begin
            pc       <= req_addr + PC_ONE;
            req_addr <= req_addr + PC_ONE;
            if (stall_any) begin
              state <= FULL;
            end else begin
              d_instr    <= imem.imem_rdata;
              d_pc_plus1 <= req_addr + PC_ONE;
              d_valid    <= 1'b1;
            end
          end else if (!ifid_stall) begin
            d_instr <= NOP_INSTR;
            d_valid <= 1'b0;
          end
        end
        FULL: begin
          if (br_taken) begin
            state    <= FETCH;
            pc       <= br_target;
            req_addr <= br_target;
            d_instr  <= NOP_INSTR;
            d_valid  <= 1'b0;
          end else if (!stall_any) begin
            state      <= FETCH;
            d_instr    <= skid_instr;
            d_pc_plus1 <= skid_pc_plus1;
            d_valid    <= skid_valid;
          end
        end
        DRAIN: begin
          d_instr <= NOP_INSTR;
          d_valid <= 1'b0;
          if (br_taken) begin
            pc <= br_target;
            if (done) begin
              state    <= FETCH;
              req_addr <= br_target;
            end
          end else if (done) begin
            state    <= FETCH;
            req_addr <= pc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
